// File: rtl/sirv_reset_sequencer.sv
//==============================================================================
// Module  : sirv_reset_sequencer
// Purpose : Stretches the synchronized reset, then releases NUM_STAGES reset
//           domains in index order, GAP_CYCLES apart. Sw/wdog requests restart.
//           Optional status ports (last cause, request count): SIRV_RSTSEQ_STATUS_EN
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sirv_reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  test_mode,
  input  logic                  io_sw_rst_req,
  input  logic                  io_wdog_rst,
  output logic [NUM_STAGES-1:0] io_stage_rst,
  output logic                  io_seq_done,
  output logic                  io_busy
`ifdef SIRV_RSTSEQ_STATUS_EN
  ,
  output logic [1:0]            io_rst_cause,
  output logic [7:0]            io_rst_count
`endif
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_GAP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [NUM_STAGES-1:0] r_stage_rst, w_stage_nxt;
  logic                  r_seq_done, w_done_nxt;
  logic                  w_req;

  assign w_req = io_sw_rst_req | io_wdog_rst;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_stage_rst <= '1;
      r_seq_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_stage_rst <= w_stage_nxt;
      r_seq_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_stage_nxt = r_stage_rst;
    w_done_nxt  = r_seq_done;
    if (w_req) begin
      // A held request parks the FSM in HOLD with the counter at zero.
      w_state_nxt = ST_HOLD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_stage_nxt = '1;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            w_stage_nxt[0] = 1'b0;
            w_cnt_nxt      = '0;
            w_idx_nxt      = IDX_W'(1);
            if (NUM_STAGES > 1) begin
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (IDX_W'(k) == r_idx) w_stage_nxt[k] = 1'b0;
            end
            w_cnt_nxt = '0;
            if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_stage_nxt = '1;
          w_done_nxt  = 1'b0;
        end
      endcase
    end
  end

  // DFT bypass hands the raw reset straight to every domain.
  assign io_stage_rst = test_mode ? {NUM_STAGES{reset}} : r_stage_rst;
  assign io_seq_done  = test_mode ? ~reset : r_seq_done;
  assign io_busy      = (r_state != ST_DONE);

`ifdef SIRV_RSTSEQ_STATUS_EN
  logic       r_req_prev;
  logic [1:0] r_rst_cause;
  logic [7:0] r_rst_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_prev  <= 1'b0;
      r_rst_cause <= 2'd0;
      r_rst_count <= 8'd0;
    end else begin
      r_req_prev <= w_req;
      if (w_req && !r_req_prev) begin
        r_rst_cause <= io_wdog_rst ? 2'd2 : 2'd1;
        if (r_rst_count != 8'hFF) r_rst_count <= r_rst_count + 8'd1;
      end
    end
  end

  assign io_rst_cause = r_rst_cause;
  assign io_rst_count = r_rst_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sirv_reset_sequencer.sv
// Bench for sirv_reset_sequencer: default 3-stage instance plus a 1-stage,
// HOLD=1 instance, checked every cycle against an elapsed-edge model.
`default_nettype none

module tb_sirv_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       test_mode = 1'b0;
  logic       sw = 1'b0;
  logic       wdog = 1'b0;
  logic [2:0] stage_a;
  logic       done_a, busy_a;
  logic [0:0] stage_b;
  logic       done_b, busy_b;
`ifdef SIRV_RSTSEQ_STATUS_EN
  logic [1:0] cause_a, cause_b;
  logic [7:0] count_a, count_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  int ecount = 0;
  int base = 0;
  int t_model = 0;
  bit chk_en = 1'b0;
  bit prev_req_m = 1'b0;
  int cause_m = 0;
  int count_m = 0;

  always #5 clock = ~clock;

  sirv_reset_sequencer dut_a (
    .clock(clock), .reset(reset), .test_mode(test_mode),
    .io_sw_rst_req(sw), .io_wdog_rst(wdog),
    .io_stage_rst(stage_a), .io_seq_done(done_a), .io_busy(busy_a)
`ifdef SIRV_RSTSEQ_STATUS_EN
    , .io_rst_cause(cause_a), .io_rst_count(count_a)
`endif
  );

  sirv_reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(4), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .test_mode(test_mode),
    .io_sw_rst_req(sw), .io_wdog_rst(wdog),
    .io_stage_rst(stage_b), .io_seq_done(done_b), .io_busy(busy_b)
`ifdef SIRV_RSTSEQ_STATUS_EN
    , .io_rst_cause(cause_b), .io_rst_count(count_b)
`endif
  );

  // Model: t = edges since the last edge that saw reset or a request.
  always @(posedge clock) begin
    ecount = ecount + 1;
    if (reset || sw || wdog) t_model = 0;
    else if (t_model < 100000) t_model = t_model + 1;
    if (reset) begin
      prev_req_m = 1'b0;
      cause_m = 0;
      count_m = 0;
    end else begin
      if ((sw || wdog) && !prev_req_m) begin
        cause_m = wdog ? 2 : 1;
        if (count_m < 255) count_m = count_m + 1;
      end
      prev_req_m = sw || wdog;
    end
  end

  function automatic logic [7:0] exp_stage(int t, int n, int hold, int gap);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = (t < hold + k * gap);
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0d)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      logic [7:0] ea, eb;
      ea = test_mode ? {5'b0, {3{reset}}} : exp_stage(t_model, 3, 16, 4);
      eb = test_mode ? {7'b0, reset} : exp_stage(t_model, 1, 1, 4);
      check("stage_a", {5'b0, stage_a}, ea);
      check("done_a", {7'b0, done_a}, {7'b0, test_mode ? ~reset : (t_model >= 24)});
      check("busy_a", {7'b0, busy_a}, {7'b0, t_model < 24});
      check("stage_b", {7'b0, stage_b}, eb);
      check("done_b", {7'b0, done_b}, {7'b0, test_mode ? ~reset : (t_model >= 1)});
      check("busy_b", {7'b0, busy_b}, {7'b0, t_model < 1});
`ifdef SIRV_RSTSEQ_STATUS_EN
      check("cause_a", {6'b0, cause_a}, 8'(cause_m));
      check("count_a", count_a, 8'(count_m));
      check("cause_b", {6'b0, cause_b}, 8'(cause_m));
      check("count_b", count_b, 8'(count_m));
`endif
    end
  end

  task automatic rebase();
    base = ecount;
  endtask

  task automatic at_edge(input int n);
    while (ecount < base + n) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    repeat (3) step();
    chk_en = 1'b1;

    // Directed: default release schedule, plus the 1-stage instance.
    reset = 1'b0;
    rebase();
    at_edge(0);
    check("lit_b_held", {6'b0, stage_b, done_b}, 8'b10);
    at_edge(1);
    check("lit_b_edge1", {6'b0, stage_b, done_b}, 8'b01);
    at_edge(15);
    check("lit_e15", {4'b0, stage_a, done_a}, 8'b1110);
    at_edge(16);
    check("lit_e16", {4'b0, stage_a, done_a}, 8'b1100);
    at_edge(20);
    check("lit_e20", {4'b0, stage_a, done_a}, 8'b1000);
    at_edge(23);
    check("lit_e23", {4'b0, stage_a, done_a}, 8'b1000);
    at_edge(24);
    check("lit_e24", {4'b0, stage_a, done_a}, 8'b0001);

    // Software request held for 3 edges while in DONE.
    at_edge(25);
    sw = 1'b1;
    at_edge(26);
    check("lit_sw_first", {4'b0, stage_a, done_a}, 8'b1110);
    at_edge(28);
    sw = 1'b0;
    rebase();
    at_edge(15);
    check("lit_sw_15", {5'b0, stage_a}, 8'b111);
    at_edge(16);
    check("lit_sw_16", {5'b0, stage_a}, 8'b110);
    at_edge(20);
    check("lit_sw_20", {5'b0, stage_a}, 8'b100);
    at_edge(24);
    check("lit_sw_24", {4'b0, stage_a, done_a}, 8'b0001);

    // Watchdog pulse mid-GAP abandons the partial release.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rebase();
    at_edge(21);
    wdog = 1'b1;
    at_edge(22);
    wdog = 1'b0;
    check("lit_wd_22", {4'b0, stage_a, done_a}, 8'b1110);
    rebase();
    at_edge(15);
    check("lit_wd_37", {5'b0, stage_a}, 8'b111);
    at_edge(16);
    check("lit_wd_38", {5'b0, stage_a}, 8'b110);
    at_edge(24);
    check("lit_wd_46", {4'b0, stage_a, done_a}, 8'b0001);

    // Test mode bypass while in DONE.
    step();
    test_mode = 1'b1;
    reset = 1'b1;
    #1;
    check("lit_tm_rst1", {4'b0, stage_a, done_a}, 8'b1110);
    step();
    reset = 1'b0;
    #1;
    check("lit_tm_rst0", {4'b0, stage_a, done_a}, 8'b0001);
    step();
    test_mode = 1'b0;
    #1;
    check("lit_tm_off", {4'b0, stage_a, done_a}, 8'b1110);

`ifdef SIRV_RSTSEQ_STATUS_EN
    step();
    sw = 1'b1;
    wdog = 1'b1;
    @(negedge clock);
    #1;
    check("lit_cause_both", {6'b0, cause_a}, 8'd2);
    check("lit_count_one", count_a, 8'd1);
    step();
    sw = 1'b0;
    wdog = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      sw = 1'b1;
      step();
      sw = 1'b0;
    end
    @(negedge clock);
    #1;
    check("lit_count_sat", count_a, 8'd255);
    check("lit_cause_sw", {6'b0, cause_a}, 8'd1);
    step();
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("lit_status_clr", {cause_a, count_a[5:0]}, 8'd0);
    step();
    reset = 1'b0;
`endif

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      step();
      reset = ($urandom_range(0, 599) == 0);
      sw = (sw && $urandom_range(0, 3) != 0) || ($urandom_range(0, 249) == 0);
      wdog = (wdog && $urandom_range(0, 2) != 0) || ($urandom_range(0, 349) == 0);
      if ($urandom_range(0, 299) == 0) test_mode = ~test_mode;
      if (test_mode && $urandom_range(0, 7) == 0) reset = 1'b1;
    end
    step();
    sw = 1'b0;
    wdog = 1'b0;
    test_mode = 1'b0;
    reset = 1'b0;
    repeat (30) step();
    @(negedge clock);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
